// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared helpers for the pipelined right barrel shifter
// Contents:
//   MAX_N               widest data path the stage helper supports
//   shamt_width_f       shift-amount width / stage count for a data width
//   right_shift_stage_f one conditional right shift by 2^k with fill, width n
package shift_pkg;

  localparam int MAX_N = 64;

  function automatic int shamt_width_f(input int n);
    return $clog2(n);
  endfunction

  // Bits at and above n are forced to zero so callers can zero-extend a
  // narrower operand into MAX_N and slice the low n bits back out.
  function automatic logic [MAX_N-1:0] right_shift_stage_f(
    input logic [MAX_N-1:0] data,
    input logic             do_shift,
    input logic             fill,
    input int               k,
    input int               n
  );
    logic [MAX_N-1:0] one;
    logic [MAX_N-1:0] valid_mask;
    logic [MAX_N-1:0] fill_mask;
    logic [MAX_N-1:0] result;
    int               step;
    one        = {{(MAX_N-1){1'b0}}, 1'b1};
    // Wraps to all ones when n == MAX_N.
    valid_mask = (one << n) - one;
    step       = 1 << k;
    // Upper 2^k positions inside the n-bit window.
    fill_mask  = valid_mask & ~(valid_mask >> step);
    result     = data & valid_mask;
    if (do_shift) begin
      result = (result >> step) | (fill ? fill_mask : '0);
    end
    return result;
  endfunction

endpackage

// File: rtl/right_shift_stage.sv
// rtl/right_shift_stage.sv - one registered stage of the right barrel shifter
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   en               pipeline advance enable; stage holds when low
//   in_vld/out_vld   slot valid
//   in_data/out_data operand before / after this stage's shift
//   in_shamt/out_shamt full shift amount carried down the pipe
//   in_fill/out_fill fill bit for vacated upper positions
module right_shift_stage
  import shift_pkg::*;
#(
  parameter int N = 8,
  parameter int K = 0,
  localparam int W = shamt_width_f(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         in_vld,
  input  logic [N-1:0] in_data,
  input  logic [W-1:0] in_shamt,
  input  logic         in_fill,
  output logic         out_vld,
  output logic [N-1:0] out_data,
  output logic [W-1:0] out_shamt,
  output logic         out_fill
);

  logic             vld_d,   vld_q;
  logic [N-1:0]     data_d,  data_q;
  logic [W-1:0]     shamt_d, shamt_q;
  logic             fill_d,  fill_q;
  logic [MAX_N-1:0] shift_full;

  always_comb begin
    shift_full = right_shift_stage_f(MAX_N'(in_data), in_shamt[K], in_fill, K, N);
  end

  if (N < MAX_N) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^shift_full[MAX_N-1:N];
  end

  always_comb begin
    vld_d   = vld_q;
    data_d  = data_q;
    shamt_d = shamt_q;
    fill_d  = fill_q;
    if (en) begin
      vld_d   = in_vld;
      data_d  = shift_full[N-1:0];
      shamt_d = in_shamt;
      fill_d  = in_fill;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q   <= 1'b0;
      data_q  <= '0;
      shamt_q <= '0;
      fill_q  <= 1'b0;
    end else begin
      vld_q   <= vld_d;
      data_q  <= data_d;
      shamt_q <= shamt_d;
      fill_q  <= fill_d;
    end
  end

  assign out_vld   = vld_q;
  assign out_data  = data_q;
  assign out_shamt = shamt_q;
  assign out_fill  = fill_q;

endmodule

// File: rtl/right_barrel_shifter_pipelined.sv
// rtl/right_barrel_shifter_pipelined.sv - pipelined logical/arithmetic right barrel shifter
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   arg_vld/arg_rdy          operand handshake; arg_rdy = !res_vld || res_rdy
//   arg_data                 N-bit operand
//   arg_shamt                right-shift amount 0..N-1
//   arg_arith                1 = sign fill, 0 = zero fill
//   res_vld/res_rdy          result handshake
//   res_data                 shifted result, straight from the last stage register
module right_barrel_shifter_pipelined
  import shift_pkg::*;
#(
  parameter int N = 8,
  localparam int W = shamt_width_f(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         arg_vld,
  output logic         arg_rdy,
  input  logic [N-1:0] arg_data,
  input  logic [W-1:0] arg_shamt,
  input  logic         arg_arith,
  output logic         res_vld,
  input  logic         res_rdy,
  output logic [N-1:0] res_data
);

  if (N < 2 || (N & (N - 1)) != 0 || N > MAX_N) begin : g_bad_n
    $error("right_barrel_shifter_pipelined: N must be a power of two in 2..MAX_N");
  end

  // Element k feeds stage k; element W is the last stage's output.
  logic [W:0]              vld_c;
  logic [W:0][N-1:0]       data_c;
  logic [W:0][W-1:0]       shamt_c;
  logic [W:0]              fill_c;
  logic                    en;

  // Whole pipe moves together; bubbles are held too, never squeezed out.
  assign en      = !res_vld || res_rdy;
  assign arg_rdy = en;

  assign vld_c[0]   = arg_vld;
  assign data_c[0]  = arg_data;
  assign shamt_c[0] = arg_shamt;
  assign fill_c[0]  = arg_arith & arg_data[N-1];

  for (genvar k = 0; k < W; k++) begin : g_stage
    right_shift_stage #(.N(N), .K(k)) u_stage (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .in_vld    (vld_c[k]),
      .in_data   (data_c[k]),
      .in_shamt  (shamt_c[k]),
      .in_fill   (fill_c[k]),
      .out_vld   (vld_c[k+1]),
      .out_data  (data_c[k+1]),
      .out_shamt (shamt_c[k+1]),
      .out_fill  (fill_c[k+1])
    );
  end

  assign res_vld  = vld_c[W];
  assign res_data = data_c[W];

  // Shift amount and fill are fully consumed by the time they leave the last stage.
  logic unused_tail;
  assign unused_tail = ^{shamt_c[W], fill_c[W]};

endmodule

// File: tb/tb_right_barrel_shifter_pipelined.sv
// tb/tb_right_barrel_shifter_pipelined.sv - scoreboard bench for right_barrel_shifter_pipelined
module tb_right_barrel_shifter_pipelined;

  logic       clk;
  logic       rst;
  logic       arg_vld;
  logic       arg_rdy;
  logic [7:0] arg_data;
  logic [2:0] arg_shamt;
  logic       arg_arith;
  logic       res_vld;
  logic       res_rdy;
  logic [7:0] res_data;

  int         n_cmp = 0;
  int         n_mis = 0;
  logic [7:0] exp_q[$];

  right_barrel_shifter_pipelined #(.N(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .arg_vld   (arg_vld),
    .arg_rdy   (arg_rdy),
    .arg_data  (arg_data),
    .arg_shamt (arg_shamt),
    .arg_arith (arg_arith),
    .res_vld   (res_vld),
    .res_rdy   (res_rdy),
    .res_data  (res_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ref_f(input logic [7:0] d, input logic [2:0] s, input logic a);
    logic signed [7:0] sd;
    logic [7:0]        r;
    sd = d;
    if (a) r = sd >>> s;
    else   r = d >> s;
    return r;
  endfunction

  // Samples the handshake just before the edge, records accepted operands, then clocks.
  task automatic step(output logic r, output logic [7:0] g, output logic a, output logic v);
    #1;
    r = res_vld && res_rdy;
    g = res_data;
    a = arg_rdy;
    v = res_vld;
    if (arg_vld && arg_rdy && !rst) exp_q.push_back(ref_f(arg_data, arg_shamt, arg_arith));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; arg_vld = 1'b0; arg_data = '0; arg_shamt = '0; arg_arith = 1'b0; res_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    n_cmp++; if (res_vld !== 1'b0) begin n_mis++; $display("FAIL reset_vld got=%b expected=0", res_vld); end
    n_cmp++; if (res_data !== 8'h00) begin n_mis++; $display("FAIL reset_data got=%h expected=00", res_data); end
    n_cmp++; if (arg_rdy !== 1'b1) begin n_mis++; $display("FAIL reset_rdy got=%b expected=1", arg_rdy); end
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (arg_rdy !== 1'b1) begin n_mis++; $display("FAIL post_reset_rdy got=%b expected=1", arg_rdy); end
  endtask

  task automatic test_logical();
    logic r, a, v; logic [7:0] g, e; int lat;
    res_rdy = 1'b1; arg_vld = 1'b1; arg_data = 8'hB4; arg_shamt = 3'd3; arg_arith = 1'b0;
    step(r, g, a, v);
    arg_vld = 1'b0;
    lat = 1;
    while (!res_vld && lat < 10) begin step(r, g, a, v); lat++; end
    n_cmp++; if (lat !== 3) begin n_mis++; $display("FAIL logical_latency got=%0d expected=3", lat); end
    n_cmp++; if (res_data !== 8'h16) begin n_mis++; $display("FAIL logical_const got=%h expected=16", res_data); end
    step(r, g, a, v);
    if (r) begin
      n_cmp++;
      if (exp_q.size() == 0) begin n_mis++; $display("FAIL logical_extra got=%h expected=none", g); end
      else begin e = exp_q.pop_front(); if (g !== e) begin n_mis++; $display("FAIL logical_data got=%h expected=%h", g, e); end end
    end else begin
      n_cmp++; n_mis++; $display("FAIL logical_retire got=0 expected=1");
    end
  endtask

  task automatic test_arith();
    logic [7:0] d_t[6] = '{8'hB4, 8'h74, 8'h80, 8'hA5, 8'hA5, 8'h80};
    logic [2:0] s_t[6] = '{3'd3, 3'd7, 3'd7, 3'd0, 3'd0, 3'd7};
    logic       a_t[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [7:0] x_t[6] = '{8'hF6, 8'h00, 8'hFF, 8'hA5, 8'hA5, 8'h01};
    logic r, a, v; logic [7:0] g, e; int k;
    k = 0;
    res_rdy = 1'b1;
    for (int c = 0; c < 14; c++) begin
      arg_vld = (c < 6);
      if (c < 6) begin arg_data = d_t[c]; arg_shamt = s_t[c]; arg_arith = a_t[c]; end
      step(r, g, a, v);
      if (r) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_mis++; $display("FAIL arith_extra got=%h expected=none", g); end
        else begin e = exp_q.pop_front(); if (g !== e) begin n_mis++; $display("FAIL arith_model got=%h expected=%h", g, e); end end
        if (k < 6) begin
          n_cmp++; if (g !== x_t[k]) begin n_mis++; $display("FAIL arith_table[%0d] got=%h expected=%h", k, g, x_t[k]); end
        end
        k++;
      end
    end
    n_cmp++; if (k !== 6) begin n_mis++; $display("FAIL arith_count got=%0d expected=6", k); end
  endtask

  task automatic test_back_to_back();
    logic r, a, v; logic [7:0] g, e; int cnt, first_c, last_c;
    cnt = 0; first_c = -1; last_c = -1;
    res_rdy = 1'b1;
    for (int c = 0; c < 16; c++) begin
      arg_vld = (c < 8);
      if (c < 8) begin arg_data = 8'(c * 8'h11); arg_shamt = 3'(c); arg_arith = c[0]; end
      step(r, g, a, v);
      if (c < 8) begin
        n_cmp++; if (a !== 1'b1) begin n_mis++; $display("FAIL b2b_rdy[%0d] got=%b expected=1", c, a); end
      end
      if (r) begin
        if (first_c < 0) first_c = c;
        last_c = c; cnt++;
        n_cmp++;
        if (exp_q.size() == 0) begin n_mis++; $display("FAIL b2b_extra got=%h expected=none", g); end
        else begin e = exp_q.pop_front(); if (g !== e) begin n_mis++; $display("FAIL b2b_data got=%h expected=%h", g, e); end end
      end
    end
    n_cmp++; if (cnt !== 8) begin n_mis++; $display("FAIL b2b_count got=%0d expected=8", cnt); end
    n_cmp++; if (first_c !== 3) begin n_mis++; $display("FAIL b2b_first got=%0d expected=3", first_c); end
    n_cmp++; if (last_c - first_c !== 7) begin n_mis++; $display("FAIL b2b_spacing got=%0d expected=7", last_c - first_c); end
  endtask

  task automatic test_backpressure();
    logic [7:0] d_t[5] = '{8'h81, 8'h42, 8'hF0, 8'h0F, 8'hC8};
    logic r, a, v; logic [7:0] g, e, held; int idx, stall_left, got_n; logic started;
    idx = 0; stall_left = 0; got_n = 0; started = 1'b0; held = '0;
    for (int c = 0; c < 40 && got_n < 5; c++) begin
      if (!started && res_vld) begin started = 1'b1; stall_left = 4; held = res_data; end
      res_rdy = (stall_left == 0);
      arg_vld = (idx < 5);
      if (idx < 5) begin arg_data = d_t[idx]; arg_shamt = 3'(idx + 1); arg_arith = idx[0]; end
      step(r, g, a, v);
      if (stall_left > 0) begin
        n_cmp++; if (a !== 1'b0) begin n_mis++; $display("FAIL bp_rdy got=%b expected=0", a); end
        n_cmp++; if (g !== held) begin n_mis++; $display("FAIL bp_hold got=%h expected=%h", g, held); end
        stall_left--;
      end
      if (arg_vld && a) idx++;
      if (r) begin
        got_n++;
        n_cmp++;
        if (exp_q.size() == 0) begin n_mis++; $display("FAIL bp_extra got=%h expected=none", g); end
        else begin e = exp_q.pop_front(); if (g !== e) begin n_mis++; $display("FAIL bp_data got=%h expected=%h", g, e); end end
      end
    end
    res_rdy = 1'b1; arg_vld = 1'b0;
    repeat (4) step(r, g, a, v);
    n_cmp++; if (r !== 1'b0) begin n_mis++; $display("FAIL bp_dup got=%b expected=0", r); end
    n_cmp++; if (got_n !== 5) begin n_mis++; $display("FAIL bp_count got=%0d expected=5", got_n); end
  endtask

  task automatic test_bubbles();
    logic r, a, v; logic [7:0] g, e; logic want;
    res_rdy = 1'b1;
    for (int c = 0; c < 12; c++) begin
      arg_vld = (c < 6) && (c % 2 == 0);
      arg_data = 8'(8'h9C + c); arg_shamt = 3'(c); arg_arith = 1'b1;
      step(r, g, a, v);
      want = (c >= 3) && (c < 9) && ((c - 3) % 2 == 0);
      n_cmp++; if (v !== want) begin n_mis++; $display("FAIL bubble_vld[%0d] got=%b expected=%b", c, v, want); end
      if (r) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_mis++; $display("FAIL bubble_extra got=%h expected=none", g); end
        else begin e = exp_q.pop_front(); if (g !== e) begin n_mis++; $display("FAIL bubble_data got=%h expected=%h", g, e); end end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic r, a, v; logic [7:0] g, e; int lat;
    res_rdy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      arg_vld = 1'b1; arg_data = 8'(8'h5A ^ c); arg_shamt = 3'(c); arg_arith = 1'b0;
      step(r, g, a, v);
    end
    arg_vld = 1'b0; rst = 1'b1;
    step(r, g, a, v);
    rst = 1'b0;
    exp_q.delete();
    n_cmp++; if (res_vld !== 1'b0) begin n_mis++; $display("FAIL rstmid_vld got=%b expected=0", res_vld); end
    n_cmp++; if (res_data !== 8'h00) begin n_mis++; $display("FAIL rstmid_data got=%h expected=00", res_data); end
    n_cmp++; if (arg_rdy !== 1'b1) begin n_mis++; $display("FAIL rstmid_rdy got=%b expected=1", arg_rdy); end
    res_rdy = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step(r, g, a, v);
      n_cmp++; if (v !== 1'b0) begin n_mis++; $display("FAIL rstmid_stale[%0d] got=%b expected=0", c, v); end
    end
    arg_vld = 1'b1; arg_data = 8'hC3; arg_shamt = 3'd2; arg_arith = 1'b1;
    step(r, g, a, v);
    arg_vld = 1'b0;
    lat = 1;
    while (!res_vld && lat < 10) begin step(r, g, a, v); lat++; end
    n_cmp++; if (lat !== 3) begin n_mis++; $display("FAIL rstmid_latency got=%0d expected=3", lat); end
    n_cmp++; if (res_data !== 8'hF0) begin n_mis++; $display("FAIL rstmid_const got=%h expected=f0", res_data); end
    step(r, g, a, v);
    if (r) begin
      n_cmp++;
      if (exp_q.size() == 0) begin n_mis++; $display("FAIL rstmid_extra got=%h expected=none", g); end
      else begin e = exp_q.pop_front(); if (g !== e) begin n_mis++; $display("FAIL rstmid_data got=%h expected=%h", g, e); end end
    end else begin
      n_cmp++; n_mis++; $display("FAIL rstmid_retire got=0 expected=1");
    end
  endtask

  initial begin
    test_reset();
    test_logical();
    test_arith();
    test_back_to_back();
    test_backpressure();
    test_bubbles();
    test_reset_mid();
    n_cmp++; if (exp_q.size() !== 0) begin n_mis++; $display("FAIL scoreboard_empty got=%0d expected=0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
